// File: rtl/alu_issue.sv
// alu_issue: decode-to-ALU issue stage for RV32I integer instructions.
// Accepts a decoded request, drives the ALU for one cycle, then captures
// the writeback value and branch decision and holds them until retired.
module alu_issue #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    input  logic            i_funct7b5,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_pc,
    output logic [3:0]      o_alu_op,
    output logic [XLEN-1:0] o_alu_ra,
    output logic [XLEN-1:0] o_alu_rb,
    input  logic [XLEN:0]   i_alu_rc,
    input  logic            i_alu_z,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_br_taken,
    output logic            o_illegal
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    // Branch-condition tag carried from accept to capture.
    typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE} br_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    state_t          state, state_nx;
    br_t             br_q, dec_br;
    logic            ill_q, dec_ill;
    alu_op_t         dec_op;
    logic [XLEN-1:0] dec_ra, dec_rb;
    logic            taken;
    logic            unused_rc_msb;

    // The ALU's carry/extension bit has no consumer here.
    assign unused_rc_msb = i_alu_rc[XLEN];

    function automatic alu_op_t arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_valid) state_nx = EXEC;
            EXEC:    state_nx = DONE;
            DONE:    if (i_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        o_ready = (state == IDLE);
    end

    // Instruction decode into ALU op, operands and branch tag.
    always_comb begin
        dec_op  = ALU_ADD;
        dec_ra  = '0;
        dec_rb  = '0;
        dec_br  = BR_NONE;
        dec_ill = 1'b0;
        case (i_opcode)
            OPC_OP: begin
                dec_op = arith_op(i_funct3, i_funct7b5);
                dec_ra = i_rs1;
                dec_rb = i_rs2;
            end
            OPC_OP_IMM: begin
                // Only the shift-right slot uses bit 30 as a selector for immediates.
                dec_op = arith_op(i_funct3, i_funct7b5 && (i_funct3 == 3'b101));
                dec_ra = i_rs1;
                dec_rb = i_imm;
            end
            OPC_LUI: begin
                dec_rb = i_imm;
            end
            OPC_AUIPC: begin
                dec_ra = i_pc;
                dec_rb = i_imm;
            end
            OPC_BRANCH: begin
                case (i_funct3)
                    3'b000: begin dec_op = ALU_SUB;  dec_br = BR_EQ; end
                    3'b001: begin dec_op = ALU_SUB;  dec_br = BR_NE; end
                    3'b100: begin dec_op = ALU_SLT;  dec_br = BR_LT; end
                    3'b101: begin dec_op = ALU_SLT;  dec_br = BR_GE; end
                    3'b110: begin dec_op = ALU_SLTU; dec_br = BR_LT; end
                    3'b111: begin dec_op = ALU_SLTU; dec_br = BR_GE; end
                    default: dec_ill = 1'b1;
                endcase
                if (!dec_ill) begin
                    dec_ra = i_rs1;
                    dec_rb = i_rs2;
                end
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Branch decision from the ALU result for the tagged condition.
    always_comb begin
        taken = 1'b0;
        case (br_q)
            BR_EQ:   taken = i_alu_z;
            BR_NE:   taken = !i_alu_z;
            BR_LT:   taken = i_alu_rc[0];
            BR_GE:   taken = !i_alu_rc[0];
            default: taken = 1'b0;
        endcase
    end

    // Datapath registers: ALU drive at accept, response capture after EXEC.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_alu_op   <= '0;
            o_alu_ra   <= '0;
            o_alu_rb   <= '0;
            br_q       <= BR_NONE;
            ill_q      <= 1'b0;
            o_result   <= '0;
            o_br_taken <= 1'b0;
            o_illegal  <= 1'b0;
            o_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        o_alu_op <= dec_op;
                        o_alu_ra <= dec_ra;
                        o_alu_rb <= dec_rb;
                        br_q     <= dec_br;
                        ill_q    <= dec_ill;
                    end
                end
                EXEC: begin
                    o_result   <= ill_q ? '0 : i_alu_rc[XLEN-1:0];
                    o_br_taken <= taken;
                    o_illegal  <= ill_q;
                    o_valid    <= 1'b1;
                end
                DONE: begin
                    if (i_ready) o_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized scoreboard bench for alu_issue with a behavioural ALU.
module tb_alu_issue;

    localparam logic [3:0] A_ADD  = 4'b0000;
    localparam logic [3:0] A_SLL  = 4'b0001;
    localparam logic [3:0] A_SLT  = 4'b0010;
    localparam logic [3:0] A_SLTU = 4'b0011;
    localparam logic [3:0] A_XOR  = 4'b0100;
    localparam logic [3:0] A_SRL  = 4'b0101;
    localparam logic [3:0] A_OR   = 4'b0110;
    localparam logic [3:0] A_AND  = 4'b0111;
    localparam logic [3:0] A_SUB  = 4'b1000;
    localparam logic [3:0] A_SRA  = 4'b1101;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [6:0]  i_opcode = '0;
    logic [2:0]  i_funct3 = '0;
    logic        i_funct7b5 = 1'b0;
    logic [31:0] i_rs1 = '0, i_rs2 = '0, i_imm = '0, i_pc = '0;
    logic [3:0]  o_alu_op;
    logic [31:0] o_alu_ra, o_alu_rb;
    logic [32:0] i_alu_rc;
    logic        i_alu_z;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_result;
    logic        o_br_taken, o_illegal;

    alu_issue #(.XLEN(32)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
        .i_opcode(i_opcode), .i_funct3(i_funct3), .i_funct7b5(i_funct7b5),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .i_pc(i_pc),
        .o_alu_op(o_alu_op), .o_alu_ra(o_alu_ra), .o_alu_rb(o_alu_rb),
        .i_alu_rc(i_alu_rc), .i_alu_z(i_alu_z),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_result(o_result), .o_br_taken(o_br_taken), .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural ALU; bit 32 carries the add/sub carry-out, which the DUT must ignore.
    always_comb begin
        i_alu_rc = '0;
        case (o_alu_op)
            A_ADD:  i_alu_rc = {1'b0, o_alu_ra} + {1'b0, o_alu_rb};
            A_SUB:  i_alu_rc = {1'b0, o_alu_ra} - {1'b0, o_alu_rb};
            A_SLL:  i_alu_rc = {1'b0, o_alu_ra << o_alu_rb[4:0]};
            A_SLT:  i_alu_rc = {32'b0, $signed(o_alu_ra) < $signed(o_alu_rb)};
            A_SLTU: i_alu_rc = {32'b0, o_alu_ra < o_alu_rb};
            A_XOR:  i_alu_rc = {1'b0, o_alu_ra ^ o_alu_rb};
            A_SRL:  i_alu_rc = {1'b0, o_alu_ra >> o_alu_rb[4:0]};
            A_SRA:  i_alu_rc = {1'b0, 32'($signed(o_alu_ra) >>> o_alu_rb[4:0])};
            A_OR:   i_alu_rc = {1'b0, o_alu_ra | o_alu_rb};
            A_AND:  i_alu_rc = {1'b0, o_alu_ra & o_alu_rb};
            default: i_alu_rc = '0;
        endcase
    end
    assign i_alu_z = (i_alu_rc[31:0] == 32'b0);

    typedef struct {
        logic [31:0] result;
        logic        br;
        logic        ill;
        logic [3:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction semantics straight from the ISA rules.
    function automatic exp_t ref_model(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                       input logic [31:0] rs1, input logic [31:0] rs2,
                                       input logic [31:0] imm, input logic [31:0] pc);
        exp_t e;
        logic [31:0] b;
        e.result = 0; e.br = 0; e.ill = 0; e.op = A_ADD; e.ra = 0; e.rb = 0;
        case (opc)
            OP, OPIMM: begin
                b = (opc == OP) ? rs2 : imm;
                e.ra = rs1; e.rb = b;
                case (f3)
                    3'd0: if (f7 && opc == OP) begin e.result = rs1 - b; e.op = A_SUB; end
                          else begin e.result = rs1 + b; e.op = A_ADD; end
                    3'd1: begin e.result = rs1 << b[4:0]; e.op = A_SLL; end
                    3'd2: begin e.result = {31'b0, $signed(rs1) < $signed(b)}; e.op = A_SLT; end
                    3'd3: begin e.result = {31'b0, rs1 < b}; e.op = A_SLTU; end
                    3'd4: begin e.result = rs1 ^ b; e.op = A_XOR; end
                    3'd5: if (f7) begin e.result = 32'($signed(rs1) >>> b[4:0]); e.op = A_SRA; end
                          else begin e.result = rs1 >> b[4:0]; e.op = A_SRL; end
                    3'd6: begin e.result = rs1 | b; e.op = A_OR; end
                    default: begin e.result = rs1 & b; e.op = A_AND; end
                endcase
            end
            LUI:   begin e.result = imm; e.rb = imm; end
            AUIPC: begin e.result = pc + imm; e.ra = pc; e.rb = imm; end
            BRANCH: begin
                e.ra = rs1; e.rb = rs2;
                case (f3)
                    3'd0: begin e.op = A_SUB;  e.result = rs1 - rs2; e.br = (rs1 == rs2); end
                    3'd1: begin e.op = A_SUB;  e.result = rs1 - rs2; e.br = (rs1 != rs2); end
                    3'd4: begin e.op = A_SLT;  e.result = {31'b0, $signed(rs1) < $signed(rs2)};
                                e.br = ($signed(rs1) < $signed(rs2)); end
                    3'd5: begin e.op = A_SLT;  e.result = {31'b0, $signed(rs1) < $signed(rs2)};
                                e.br = ($signed(rs1) >= $signed(rs2)); end
                    3'd6: begin e.op = A_SLTU; e.result = {31'b0, rs1 < rs2}; e.br = (rs1 < rs2); end
                    3'd7: begin e.op = A_SLTU; e.result = {31'b0, rs1 < rs2}; e.br = (rs1 >= rs2); end
                    default: begin e.ill = 1; e.ra = 0; e.rb = 0; end
                endcase
            end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    // Monitor: every response the consumer accepts is compared with the oldest expectation.
    always @(negedge i_clk) begin : monitor
        exp_t e;
        if (i_rstn && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid: got result 0x%08h expected no response", o_result);
            end else begin
                e = sb.pop_front();
                chk("result",   o_result,   e.result);
                chk("br_taken", 32'(o_br_taken), 32'(e.br));
                chk("illegal",  32'(o_illegal),  32'(e.ill));
                chk("alu_op",   32'(o_alu_op),   32'(e.op));
                chk("alu_ra",   o_alu_ra,   e.ra);
                chk("alu_rb",   o_alu_rb,   e.rb);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!o_ready && n < 20) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk("ready_timeout", 32'(o_ready), 32'd1);
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pc);
        i_opcode = opc; i_funct3 = f3; i_funct7b5 = f7;
        i_rs1 = rs1; i_rs2 = rs2; i_imm = imm; i_pc = pc;
    endtask

    task automatic scramble();
        drive(7'($urandom), 3'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom);
    endtask

    // One full transaction; stall cycles of backpressure, optionally poking i_valid while held.
    task automatic run_txn(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm, input logic [31:0] pc,
                           input int stall, input bit poke);
        logic [31:0] s_res, s_ra, s_rb;
        logic [3:0]  s_op;
        logic        s_br, s_ill;
        wait_ready();
        sb.push_back(ref_model(opc, f3, f7, rs1, rs2, imm, pc));
        drive(opc, f3, f7, rs1, rs2, imm, pc);
        i_valid = 1'b1;
        i_ready = (stall == 0);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        scramble();
        chk("t0_valid", 32'(o_valid), 32'd0);
        chk("t0_ready", 32'(o_ready), 32'd0);
        @(posedge i_clk); #1;
        chk("t1_valid", 32'(o_valid), 32'd1);
        s_res = o_result; s_ra = o_alu_ra; s_rb = o_alu_rb; s_op = o_alu_op;
        s_br = o_br_taken; s_ill = o_illegal;
        for (int s = 0; s < stall; s++) begin
            if (poke) begin
                i_valid = 1'b1;
                scramble();
            end
            @(posedge i_clk); #1;
            chk("hold_valid",  32'(o_valid), 32'd1);
            chk("hold_ready",  32'(o_ready), 32'd0);
            chk("hold_result", o_result, s_res);
            chk("hold_ops",    {o_alu_ra ^ s_ra} | {o_alu_rb ^ s_rb}, 32'd0);
            chk("hold_flags",  {26'b0, o_alu_op, o_br_taken, o_illegal}, {26'b0, s_op, s_br, s_ill});
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        chk("retire_valid", 32'(o_valid), 32'd0);
        chk("retire_ready", 32'(o_ready), 32'd1);
        i_ready = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"},  32'(o_valid), 32'd0);
        chk({tag, "_ready"},  32'(o_ready), 32'd1);
        chk({tag, "_result"}, o_result, 32'd0);
        chk({tag, "_flags"},  {28'b0, o_br_taken, o_illegal, 2'b0}, 32'd0);
        chk({tag, "_alu_op"}, 32'(o_alu_op), 32'd0);
        chk({tag, "_alu_ra"}, o_alu_ra, 32'd0);
        chk({tag, "_alu_rb"}, o_alu_rb, 32'd0);
    endtask

    // Start a transaction and reset it in EXEC (in_done=0) or DONE (in_done=1).
    task automatic abort_txn(input bit in_done);
        wait_ready();
        drive(OP, 3'd0, 1'b0, 32'h1234, 32'h1111, 32'h0, 32'h0);
        i_valid = 1'b1;
        i_ready = 1'b0;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        if (in_done) begin
            @(posedge i_clk); #1;
            chk("abort_pre_valid", 32'(o_valid), 32'd1);
        end
        i_rstn = 1'b0;
        @(posedge i_clk); #1;
        check_reset_state(in_done ? "rst_done" : "rst_exec");
        i_rstn = 1'b1;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin : stim
        logic [6:0]  opc;
        logic [31:0] a, b;
        i_rstn = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_state("por");
        i_rstn = 1'b1;
        @(posedge i_clk); #1;
        chk("por_ready_after", 32'(o_ready), 32'd1);

        run_txn(OP,     3'b000, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 0, 0);
        run_txn(OPIMM,  3'b101, 1'b1, 32'h8000_0000, 32'h0, 32'h404, 32'h0, 0, 0);
        run_txn(BRANCH, 3'b000, 1'b0, 32'd5, 32'd5, 32'h0, 32'h0, 0, 0);
        run_txn(BRANCH, 3'b001, 1'b0, 32'd5, 32'd5, 32'h0, 32'h0, 0, 0);
        run_txn(BRANCH, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 0, 0);
        run_txn(BRANCH, 3'b111, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 0, 0);
        run_txn(BRANCH, 3'b110, 1'b0, 32'd0, 32'd0, 32'h0, 32'h0, 0, 0);
        run_txn(OP,     3'b000, 1'b1, 32'd7, 32'd9, 32'h0, 32'h0, 5, 1);
        run_txn(7'b0000011, 3'b010, 1'b0, 32'h55, 32'h66, 32'h77, 32'h0, 0, 0);
        run_txn(BRANCH, 3'b010, 1'b0, 32'h55, 32'h55, 32'h0, 32'h0, 1, 0);
        run_txn(LUI,    3'b000, 1'b0, 32'hAAAA, 32'h0, 32'hABCD_E000, 32'h40, 0, 0);
        run_txn(OPIMM,  3'b000, 1'b1, 32'd10, 32'd0, 32'hFFFF_FFFF, 32'h0, 0, 0);

        abort_txn(1'b0);
        abort_txn(1'b1);
        run_txn(AUIPC, 3'b000, 1'b0, 32'h0, 32'h0, 32'h2000, 32'h1000, 0, 0);

        for (int n = 0; n < 150; n++) begin
            a = rnd_val();
            b = ($urandom_range(0, 3) == 0) ? a : rnd_val();
            case ($urandom_range(0, 9))
                0, 1, 2: opc = OP;
                3, 4:    opc = OPIMM;
                5:       opc = LUI;
                6:       opc = AUIPC;
                7, 8:    opc = BRANCH;
                default: begin
                    opc = 7'($urandom);
                    if (opc == OP || opc == OPIMM || opc == LUI || opc == AUIPC || opc == BRANCH)
                        opc = 7'b0000011;
                end
            endcase
            run_txn(opc, 3'($urandom), 1'($urandom), a, b, rnd_val(), $urandom,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                    1'($urandom));
        end

        repeat (4) @(posedge i_clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Initiator side of the ALU interface: accepts one decoded RV32I integer instruction per transaction through a valid/ready handshake.
- Derives the ALU operation code and both operands, drives the ALU combinationally, then captures its result and zero flag.
- Returns the writeback value and the branch decision to the execute stage through a second valid/ready handshake.
- Sits between the decode stage and the ALU inside the core's execute stage.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- i_clk  input  1  clock; all logic samples on the rising edge.
- i_rstn  input  1  synchronous active-low reset.
- i_valid  input  1  request valid from decode.
- o_ready  output  1  block can accept a request; equals (state == IDLE).
- i_opcode  input  7  RV32I opcode field.
- i_funct3  input  3  funct3 field.
- i_funct7b5  input  1  instruction bit 30.
- i_rs1  input  XLEN  rs1 register value.
- i_rs2  input  XLEN  rs2 register value.
- i_imm  input  XLEN  sign-extended or shifted immediate, already formed by decode.
- i_pc  input  XLEN  instruction address.
- o_alu_op  output  4  to ALU i_op; codes are the ALU_* encodings from ALU_DEFINES.vh.
- o_alu_ra  output  XLEN  to ALU i_Ra.
- o_alu_rb  output  XLEN  to ALU i_Rb.
- i_alu_rc  input  XLEN+1  from ALU o_Rc; bit 32 is ignored.
- i_alu_z  input  1  from ALU o_Z; true when i_alu_rc[31:0] == 0.
- o_valid  output  1  response valid.
- i_ready  input  1  response accepted by the consumer.
- o_result  output  XLEN  writeback value.
- o_br_taken  output  1  branch condition is true.
- o_illegal  output  1  unsupported opcode or funct3.

Behaviour:
- Reset, synchronous, i_rstn = 0 at an edge:
  - state goes to IDLE.
  - o_valid, o_br_taken, o_illegal, o_result, o_alu_op, o_alu_ra, o_alu_rb all go to 0.
  - o_ready reads 1 from the first cycle after reset.
- Reset mid-transaction aborts it: no o_valid is produced and the pending result is discarded.
- States:
  - IDLE: o_ready = 1. On i_valid at edge T0, register o_alu_op/ra/rb and a branch-type tag, then go to EXEC.
  - EXEC: the ALU evaluates combinationally. At edge T1, capture o_result = i_alu_rc[31:0] and o_br_taken, set o_valid, and go to DONE.
  - DONE: hold every output stable while o_valid && !i_ready. On i_ready at an edge, clear o_valid and go to IDLE.
- Timing:
  - Minimum latency: accept edge to o_valid high is 2 edges.
  - Throughput: 1 transaction per 3 cycles.
  - No overlap of accept and retire.
- Decode for OP (0110011):
  - funct3 000: ADD, or SUB when funct7b5 = 1.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: SRL, or SRA when funct7b5 = 1.
  - 110: OR. 111: AND.
  - Operands: Ra = rs1, Rb = rs2.
- Decode for OP-IMM (0010011):
  - Same table as OP, except funct3 000 is always ADD.
  - Operands: Ra = rs1, Rb = imm.
  - Shift amount is Rb[4:0], supplied by the ALU.
- Decode for LUI (0110111): ADD, Ra = 0, Rb = imm.
- Decode for AUIPC (0010111): ADD, Ra = pc, Rb = imm.
- Decode for BRANCH (1100011), operands Ra = rs1, Rb = rs2:
  - BEQ/BNE (000/001): SUB; taken = i_alu_z, or !i_alu_z for BNE.
  - BLT/BGE (100/101): SLT; taken = rc[0], or !rc[0] for BGE.
  - BLTU/BGEU (110/111): SLTU; taken = rc[0], or !rc[0] for BGEU.
  - o_result is the raw ALU value.
- o_br_taken is 0 for every non-branch instruction.
- Illegal requests (any other opcode, or branch funct3 010/011):
  - Accepted normally and follow the same IDLE→EXEC→DONE timing.
  - o_alu_op = ADD, Ra = Rb = 0.
  - Response: o_illegal = 1, o_result = 0, o_br_taken = 0.
- The o_alu_* registers hold their value after DONE until the next accept.
- i_valid is ignored outside IDLE. Request inputs are sampled only at the accept edge.

Test Plan:
- OP ADD: rs1=0xFFFFFFFF, rs2=1, funct7b5=0 → o_alu_op=ALU_ADD; o_result=0 two edges after accept, o_br_taken=0, o_illegal=0.
- OP-IMM SRAI: rs1=0x80000000, imm=0x404, funct3=101, funct7b5=1 → ALU_SRA, Rb=0x404, o_result=0xF8000000.
- BRANCH: BEQ 5,5 → taken=1; BNE 5,5 → 0; BLT 0xFFFFFFFF,1 → 1; BGEU 0xFFFFFFFF,1 → 1; BLTU 0,0 → 0, o_result=0.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid → outputs stable, o_ready=0, new i_valid ignored; i_ready=1 → o_valid drops and o_ready=1 next cycle.
- Illegal: opcode 0000011, and BRANCH funct3=010 → o_valid after 2 edges with o_illegal=1, o_result=0, o_br_taken=0.
- Reset: i_rstn=0 in EXEC, and again in DONE → next cycle o_valid=0, o_ready=1, all outputs 0. AUIPC pc=0x1000, imm=0x2000 afterwards → o_result=0x3000.
